// File: rtl/eth_pkg.sv
// Shared RMII receive types: FSM states, line constants and the FIFO entry layout.
// Purely declarative; no logic and no timing of its own.
package eth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_e;

  localparam logic [1:0] RMII_PRE = 2'b01;
  localparam logic [1:0] RMII_SFD = 2'b11;

  localparam int ENT_DATA_W = 8;
  localparam int ENT_W      = ENT_DATA_W + 3;

  typedef struct packed {
    logic                  sof;
    logic                  eof;
    logic                  err;
    logic [ENT_DATA_W-1:0] data;
  } rx_entry_t;

  function automatic rx_entry_t make_entry(input logic sof, input logic eof, input logic err,
                                           input logic [ENT_DATA_W-1:0] data);
    rx_entry_t e;
    e.sof  = sof;
    e.eof  = eof;
    e.err  = err;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/sfifo_fwft.sv
// Synchronous first-word-fall-through FIFO; a write shows at o_dout one cycle later.
// Push on full is ignored unless a pop happens in the same cycle; o_dout reads 0 when empty.
module sfifo_fwft #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign o_full  = (count_q == (AW+1)'(DEPTH));
  assign o_empty = (count_q == '0);
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~o_full | do_pop);
  assign o_dout  = o_empty ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_din;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rmii_rx_frame.sv
// RMII receiver: preamble/SFD hunt, dibit-to-byte assembly, one-byte skid, FWFT output FIFO.
// Byte reaches FIFO one byte-time after completion; FIFO overflow drops the frame and counts it.
module rmii_rx_frame #(
  parameter int FIFO_DEPTH = 16,
  parameter int PRE_MIN    = 4,
  parameter int DIV10      = 10
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_speed_100,
  input  logic        i_ethphy_crsdv,
  input  logic        i_ethphy_rxer,
  input  logic [1:0]  i_ethphy_rxd,
  output logic        o_rx_vld,
  input  logic        i_rx_rdy,
  output logic [7:0]  o_rx_data,
  output logic        o_rx_sof,
  output logic        o_rx_eof,
  output logic        o_rx_err,
  output logic [15:0] o_ovf_cnt
);

  import eth_pkg::*;

  localparam int CW  = (DIV10 > 1) ? $clog2(DIV10) : 1;
  localparam int PCW = $clog2(PRE_MIN + 1);
  localparam logic [CW-1:0]  CNT_MID  = CW'(DIV10 / 2);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DIV10 - 1);
  localparam logic [PCW-1:0] PRE_SAT  = PCW'(PRE_MIN);

  logic       crsdv_q, rxer_q, spd_q, spd_prev_q;
  logic [1:0] rxd_q;

  rx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PCW-1:0]  pre_cnt_q, pre_cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [5:0]      sr_q, sr_d;
  logic [7:0]      skid_dat_q, skid_dat_d;
  logic            skid_vld_q, skid_vld_d, skid_sof_q, skid_sof_d;
  logic            first_q, first_d, err_q, err_d, crs_low_q, crs_low_d;
  logic            sof_wr_q, sof_wr_d, pend_term_q, pend_term_d;
  logic [15:0]     ovf_cnt_q, ovf_cnt_d;

  logic      strobe, spd_chg;
  logic      byte_done, frame_end, push_data, push_end, push_req, push_term;
  logic      ovf, ovf_inc;
  logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
  rx_entry_t fifo_din, fifo_dout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crsdv_q    <= 1'b0;
      rxer_q     <= 1'b0;
      rxd_q      <= 2'b00;
      spd_q      <= 1'b0;
      spd_prev_q <= 1'b0;
    end else begin
      crsdv_q    <= i_ethphy_crsdv;
      rxer_q     <= i_ethphy_rxer;
      rxd_q      <= i_ethphy_rxd;
      spd_q      <= i_speed_100;
      spd_prev_q <= spd_q;
    end
  end

  assign strobe  = spd_q | (cnt_q == CNT_MID);
  assign spd_chg = spd_q ^ spd_prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (strobe) begin
      case (state_q)
        ST_IDLE: begin
          if (crsdv_q && rxd_q == RMII_PRE) state_d = pend_term_q ? ST_DROP : ST_PREAMBLE;
        end
        ST_PREAMBLE: begin
          if (!crsdv_q)                                       state_d = ST_IDLE;
          else if (rxd_q == RMII_SFD && pre_cnt_q >= PRE_SAT) state_d = ST_DATA;
          else if (rxd_q != RMII_PRE)                         state_d = ST_IDLE;
        end
        ST_DATA: begin
          if (frame_end) state_d = ST_IDLE;
          else if (ovf)  state_d = ST_DROP;
        end
        default: begin
          if (!crsdv_q && crs_low_q) state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    byte_done = (state_q == ST_DATA) && strobe && crsdv_q && (idx_q == 2'd3);
    frame_end = (state_q == ST_DATA) && strobe && !crsdv_q && ((idx_q == 2'd0) || crs_low_q);
    push_data = byte_done && skid_vld_q;
    push_end  = frame_end;
    push_req  = push_data || push_end;
    fifo_pop  = !fifo_empty && i_rx_rdy;
    ovf       = push_req && fifo_full && !fifo_pop;
    push_term = pend_term_q && !fifo_full && !push_req;
    fifo_push = push_req || push_term;
    ovf_inc   = ovf || ((state_q == ST_IDLE) && strobe && crsdv_q && (rxd_q == RMII_PRE) && pend_term_q);
    fifo_din  = make_entry(skid_sof_q, 1'b0, 1'b0, skid_dat_q);
    if (push_end) begin
      // A partial byte or an empty frame both end as an errored eof entry.
      if (skid_vld_q)
        fifo_din = make_entry(skid_sof_q, 1'b1,
                              err_q || rxer_q || spd_chg || (idx_q != 2'd0), skid_dat_q);
      else
        fifo_din = make_entry(1'b1, 1'b1, 1'b1, 8'h00);
    end else if (push_term) begin
      fifo_din = make_entry(1'b0, 1'b1, 1'b1, 8'h00);
    end
  end

  always_comb begin
    cnt_d       = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    crs_low_d   = crs_low_q;
    pre_cnt_d   = pre_cnt_q;
    idx_d       = idx_q;
    sr_d        = sr_q;
    skid_dat_d  = skid_dat_q;
    skid_vld_d  = skid_vld_q;
    skid_sof_d  = skid_sof_q;
    first_d     = first_q;
    err_d       = err_q;
    sof_wr_d    = sof_wr_q;
    pend_term_d = pend_term_q;
    ovf_cnt_d   = ovf_cnt_q;
    // Hold the divider at zero so the first sample after carrier lands mid-dibit.
    if (state_q == ST_IDLE && !crsdv_q) cnt_d = '0;
    if (strobe) crs_low_d = !crsdv_q;
    case (state_q)
      ST_IDLE: begin
        if (state_d == ST_PREAMBLE) begin
          pre_cnt_d  = PCW'(1);
          idx_d      = 2'd0;
          skid_vld_d = 1'b0;
          first_d    = 1'b1;
          err_d      = 1'b0;
          sof_wr_d   = 1'b0;
        end
      end
      ST_PREAMBLE: begin
        if (spd_chg) err_d = 1'b1;
        if (strobe && crsdv_q && rxd_q == RMII_PRE && pre_cnt_q != PRE_SAT)
          pre_cnt_d = pre_cnt_q + 1'b1;
      end
      ST_DATA: begin
        if (rxer_q || spd_chg) err_d = 1'b1;
        if (strobe && crsdv_q) begin
          case (idx_q)
            2'd0:    sr_d[1:0] = rxd_q;
            2'd1:    sr_d[3:2] = rxd_q;
            2'd2:    sr_d[5:4] = rxd_q;
            default: begin
              skid_dat_d = {rxd_q, sr_q};
              skid_sof_d = first_q;
              skid_vld_d = 1'b1;
              first_d    = 1'b0;
            end
          endcase
          idx_d = idx_q + 1'b1;
        end
        if (frame_end || ovf) begin
          skid_vld_d = 1'b0;
          idx_d      = 2'd0;
        end
      end
      default: ;
    endcase
    if (push_req && !ovf && fifo_din.sof) sof_wr_d = 1'b1;
    if (ovf && sof_wr_q)  pend_term_d = 1'b1;
    else if (push_term)   pend_term_d = 1'b0;
    if (ovf_inc && ovf_cnt_q != 16'hFFFF) ovf_cnt_d = ovf_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q       <= '0;
      crs_low_q   <= 1'b0;
      pre_cnt_q   <= '0;
      idx_q       <= 2'd0;
      sr_q        <= 6'd0;
      skid_dat_q  <= 8'd0;
      skid_vld_q  <= 1'b0;
      skid_sof_q  <= 1'b0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      sof_wr_q    <= 1'b0;
      pend_term_q <= 1'b0;
      ovf_cnt_q   <= 16'd0;
    end else begin
      cnt_q       <= cnt_d;
      crs_low_q   <= crs_low_d;
      pre_cnt_q   <= pre_cnt_d;
      idx_q       <= idx_d;
      sr_q        <= sr_d;
      skid_dat_q  <= skid_dat_d;
      skid_vld_q  <= skid_vld_d;
      skid_sof_q  <= skid_sof_d;
      first_q     <= first_d;
      err_q       <= err_d;
      sof_wr_q    <= sof_wr_d;
      pend_term_q <= pend_term_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  sfifo_fwft #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (fifo_push),
    .i_din   (fifo_din),
    .i_pop   (fifo_pop),
    .o_dout  (fifo_dout),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign o_rx_vld  = !fifo_empty;
  assign o_rx_data = fifo_dout.data;
  assign o_rx_sof  = fifo_dout.sof;
  assign o_rx_eof  = fifo_dout.eof;
  assign o_rx_err  = fifo_dout.err & fifo_dout.eof;
  assign o_ovf_cnt = ovf_cnt_q;

endmodule

// File: tb/tb_rmii_rx_frame.sv
// Directed bench for rmii_rx_frame: frame table plus overflow and mid-frame reset sequences.
module tb_rmii_rx_frame;

  logic        clk = 1'b0;
  logic        rst_n, spd, crs, rxer, rdy;
  logic [1:0]  rxd;
  logic        vld, sof, eof, err;
  logic [7:0]  data;
  logic [15:0] ovf_cnt;

  always #5 clk = ~clk;

  rmii_rx_frame #(.FIFO_DEPTH(4), .PRE_MIN(4), .DIV10(10)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_speed_100    (spd),
    .i_ethphy_crsdv (crs),
    .i_ethphy_rxer  (rxer),
    .i_ethphy_rxd   (rxd),
    .o_rx_vld       (vld),
    .i_rx_rdy       (rdy),
    .o_rx_data      (data),
    .o_rx_sof       (sof),
    .o_rx_eof       (eof),
    .o_rx_err       (err),
    .o_ovf_cnt      (ovf_cnt)
  );

  typedef struct {
    bit          spd;
    int          npre;
    logic [79:0] bytes;
    int          nb;
    int          nextra;
    int          er_byte;
    int          exp_n;
    bit          exp_err;
    logic [7:0]  exp_last;
  } vec_t;

  vec_t        tbl [8];
  vec_t        big;
  logic [10:0] rxq [$];
  logic [10:0] ovf_exp [5];
  int          n_vec = 0;
  int          n_bad = 0;

  always @(negedge clk) begin
    if (vld && rdy) rxq.push_back({sof, eof, err, data});
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic dibit(input logic c, input logic [1:0] d, input logic e, input int hold);
    crs  = c;
    rxd  = d;
    rxer = e;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input vec_t v);
    int hold;
    hold = v.spd ? 1 : 10;
    spd  = v.spd;
    repeat (4) dibit(1'b0, 2'b00, 1'b0, hold);
    for (int p = 0; p < v.npre; p++) dibit(1'b1, 2'b01, 1'b0, hold);
    dibit(1'b1, 2'b11, 1'b0, hold);
    for (int i = 0; i < v.nb; i++)
      for (int k = 0; k < 4; k++)
        dibit(1'b1, v.bytes[i*8 + k*2 +: 2], (i == v.er_byte) && (k == 1), hold);
    for (int x = 0; x < v.nextra; x++) dibit(1'b1, 2'b10, 1'b0, hold);
    repeat (6) dibit(1'b0, 2'b00, 1'b0, hold);
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    logic [7:0]  d;
    logic [10:0] e;
    logic [10:0] got;
    rdy = 1'b1;
    rxq.delete();
    send_frame(v);
    for (int t = 0; t < 300 && rxq.size() < v.exp_n; t++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    chk($sformatf("v%0d_count", vi), 32'(rxq.size()), 32'(v.exp_n));
    for (int j = 0; j < v.exp_n && j < rxq.size(); j++) begin
      d   = (v.nb == 0) ? 8'h00 : v.bytes[j*8 +: 8];
      e   = {(j == 0), (j == v.exp_n - 1), (j == v.exp_n - 1) && v.exp_err, d};
      got = rxq[j];
      chk($sformatf("v%0d_entry%0d", vi, j), 32'(got), 32'(e));
    end
    if (v.exp_n > 0 && rxq.size() == v.exp_n) begin
      got = rxq[v.exp_n - 1];
      chk($sformatf("v%0d_last_data", vi), 32'(got[7:0]), 32'(v.exp_last));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    spd   = 1'b1;
    crs   = 1'b0;
    rxer  = 1'b0;
    rxd   = 2'b00;
    rdy   = 1'b1;

    tbl[0] = '{1'b1, 7, 80'h12D555, 3, 0, -1, 3, 1'b0, 8'h12};
    tbl[1] = '{1'b0, 7, 80'h12D555, 3, 0, -1, 3, 1'b0, 8'h12};
    tbl[2] = '{1'b1, 7, 80'hC3B2A1, 3, 0,  1, 3, 1'b1, 8'hC3};
    tbl[3] = '{1'b1, 7, 80'h3412,   2, 2, -1, 2, 1'b1, 8'h34};
    tbl[4] = '{1'b1, 7, 80'h0,      0, 0, -1, 1, 1'b1, 8'h00};
    tbl[5] = '{1'b0, 7, 80'hFF,     1, 0,  0, 1, 1'b1, 8'hFF};
    tbl[6] = '{1'b1, 3, 80'h0000,   2, 0, -1, 0, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 4, 80'h3C,     1, 0, -1, 1, 1'b0, 8'h3C};
    big    = '{1'b1, 7, 80'h0A090807060504030201, 10, 0, -1, 0, 1'b0, 8'h00};
    ovf_exp[0] = 11'h401;
    ovf_exp[1] = 11'h002;
    ovf_exp[2] = 11'h003;
    ovf_exp[3] = 11'h004;
    ovf_exp[4] = 11'h300;

    #12;
    chk("rst_vld",  32'(vld),     32'd0);
    chk("rst_data", 32'(data),    32'd0);
    chk("rst_sof",  32'(sof),     32'd0);
    chk("rst_eof",  32'(eof),     32'd0);
    chk("rst_err",  32'(err),     32'd0);
    chk("rst_ovf",  32'(ovf_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    // Overflow: stalled consumer, 10-byte frame into a 4-entry FIFO.
    rdy = 1'b0;
    rxq.delete();
    send_frame(big);
    repeat (10) @(posedge clk);
    #1;
    chk("ovf_cnt",       32'(ovf_cnt),               32'd1);
    chk("ovf_hold_vld",  32'(vld),                   32'd1);
    chk("ovf_hold_head", 32'({sof, eof, err, data}), 32'h401);
    rdy = 1'b1;
    for (int t = 0; t < 100 && rxq.size() < 5; t++) @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    chk("ovf_count", 32'(rxq.size()), 32'd5);
    for (int j = 0; j < 5 && j < rxq.size(); j++)
      chk($sformatf("ovf_entry%0d", j), 32'(rxq[j]), 32'(ovf_exp[j]));
    run_vec(8, tbl[0]);
    chk("ovf_cnt_after", 32'(ovf_cnt), 32'd1);

    // Reset asserted mid-DATA with entries waiting in the FIFO.
    rdy = 1'b0;
    rxq.delete();
    spd = 1'b1;
    repeat (4) dibit(1'b0, 2'b00, 1'b0, 1);
    repeat (7) dibit(1'b1, 2'b01, 1'b0, 1);
    dibit(1'b1, 2'b11, 1'b0, 1);
    for (int i = 1; i <= 3; i++) begin
      logic [7:0] b;
      b = 8'(i);
      for (int k = 0; k < 4; k++) dibit(1'b1, b[k*2 +: 2], 1'b0, 1);
    end
    chk("prerst_vld",  32'(vld),                   32'd1);
    chk("prerst_head", 32'({sof, eof, err, data}), 32'h401);
    rst_n = 1'b0;
    #1;
    chk("midrst_vld",  32'(vld),     32'd0);
    chk("midrst_data", 32'(data),    32'd0);
    chk("midrst_sof",  32'(sof),     32'd0);
    chk("midrst_eof",  32'(eof),     32'd0);
    chk("midrst_err",  32'(err),     32'd0);
    chk("midrst_ovf",  32'(ovf_cnt), 32'd0);
    crs = 1'b1;
    rxd = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (8) dibit(1'b1, 2'b00, 1'b0, 1);
    repeat (6) dibit(1'b0, 2'b00, 1'b0, 1);
    rdy = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("postrst_empty", 32'(rxq.size()), 32'd0);
    run_vec(9, tbl[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rmii_rx_frame.md
RMII_RX_FRAME -- requirements
Module: rmii_rx_frame

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, output FIFO entries; power of 2, minimum 4.
REQ-002 Parameter PRE_MIN, default 4, minimum count of consecutive 2'b01 dibits that must precede the SFD.
REQ-003 Parameter DIV10, default 10, number of i_clk cycles per dibit in 10 Mb/s mode.
REQ-004 i_clk  in  1  50 MHz RMII reference clock; the only clock.
REQ-005 i_rst_n  in  1  Asynchronous, active-low reset.
REQ-006 i_speed_100  in  1  1 = 100 Mb/s (a dibit every cycle); 0 = 10 Mb/s (a dibit every DIV10 cycles). Static while a frame is in progress.
REQ-007 i_ethphy_crsdv  in  1  RMII CRS_DV.
REQ-008 i_ethphy_rxer  in  1  RMII RX_ER.
REQ-009 i_ethphy_rxd  in  2  RMII RXD.
REQ-010 o_rx_vld  out  1  Head FIFO entry is valid.
REQ-011 i_rx_rdy  in  1  Consumer accepts the entry; a transfer occurs when o_rx_vld and i_rx_rdy are both 1.
REQ-012 o_rx_data  out  8  Received byte.
REQ-013 o_rx_sof  out  1  Marks the first byte after the SFD.
REQ-014 o_rx_eof  out  1  Marks the last entry of the frame.
REQ-015 o_rx_err  out  1  Frame error; valid only with o_rx_eof.
REQ-016 o_ovf_cnt  out  16  Count of dropped frames; saturates at 16'hFFFF.

Function
REQ-017 Input registers: every RMII input is registered once before use.
REQ-018 Sample strobe: 1 every cycle when i_speed_100=1; otherwise 1 once per DIV10 cycles. The divider counter restarts at the first cycle CRS_DV is high in IDLE, so the first sample lands mid-dibit at count DIV10/2.
REQ-019 States are IDLE, PREAMBLE, DATA and DROP. Every transition happens only on a sample strobe.
REQ-020 IDLE -> PREAMBLE when CRS_DV=1 and RXD=01.
REQ-021 PREAMBLE: the block counts 01 dibits. It moves to DATA when RXD=11 and the count is at least PRE_MIN. It returns to IDLE on CRS_DV=0 or on any other pattern.
REQ-022 DATA: the block assembles 4 dibits LSB-first (first dibit goes to bits[1:0]) into a byte.
REQ-023 Skid register: each completed byte is held in a one-entry skid register. It is pushed to the FIFO when the next byte completes (eof=0) or when the frame ends (eof=1). This gives latency of one byte from completion to FIFO write, plus one cycle to o_rx_vld.
REQ-024 Frame end is CRS_DV=0 on two consecutive strobes, or CRS_DV=0 at dibit index 0. The block then returns to IDLE.
REQ-025 Error flag err is set by any of the following during DATA:
- RXER=1;
- a frame end with a partial byte (dibit index 1-3); the partial byte is discarded;
- a frame end with zero bytes.
REQ-026 Zero-byte frame: if the frame ends with no bytes, the block writes a single entry with data=0, sof=1, eof=1, err=1.
REQ-027 FIFO entry format: {sof, eof, err, data[7:0]}, 11 bits. It is a synchronous FIFO with first-word-fall-through output.
REQ-028 Overflow: a push while the FIFO is full is discarded. The block enters DROP, increments o_ovf_cnt and sets a pending-terminate flag.
REQ-029 DROP -> IDLE at frame end. If the frame's sof entry was already written, a terminator entry {sof=0, eof=1, err=1, data=0} is pushed at the first cycle the FIFO is not full, before any new frame is accepted. Frames arriving meanwhile count as overflow.
REQ-030 Simultaneous push and pop on a full FIFO is allowed and is not an overflow.
REQ-031 Speed change: a change of i_speed_100 outside IDLE is treated as an error, with the same handling as REQ-025.

Reset
REQ-032 While i_rst_n=0, asynchronously:
- state=IDLE and the FIFO is empty;
- the divider, dibit index and skid register are cleared;
- o_rx_vld=0, o_rx_data=0, o_rx_sof=0, o_rx_eof=0, o_rx_err=0, o_ovf_cnt=0.
REQ-033 Reset mid-frame discards the partial frame. After release, no entry is emitted until a new preamble and SFD are received.

Structure
REQ-034 Shared package eth_pkg holds the state enumeration, the RMII constants (PRE=2'b01, SFD=2'b11) and the FIFO entry field widths.
REQ-035 The FIFO is the sub-module sfifo_fwft, parameterised in WIDTH and DEPTH, with full, empty, push and pop ports.

Verification
REQ-036 100 Mb/s: 7 PRE dibits, SFD, bytes 0x55 0xD5 0x12, then CRS_DV low. Required: 3 entries; the first has sof=1; the last has data=0x12 and eof=1; err=0.
REQ-037 10 Mb/s, DIV10=10: the same frame, each dibit held 10 cycles. Required: identical entries.
REQ-038 RXER pulse during the second byte. Required: the last entry has err=1 and eof=1.
REQ-039 Frame ends after 2 bytes plus 2 extra dibits. Required: 2 entries; the second has eof=1 and err=1.
REQ-040 i_rx_rdy=0, FIFO_DEPTH=4, 10-byte frame, then i_rx_rdy=1. Required:
- o_ovf_cnt=1;
- 4 data entries, then a terminator with eof=1 and err=1;
- the next frame is received cleanly.
REQ-041 Assert reset mid-DATA. Required: all outputs are 0 immediately; the following frame is received correctly.
